// File: rtl/seq_det_pkg.sv
// Shared types and width helpers for the programmable serial sequence detector.
// The struct field widths follow the package defaults; instantiate the
// detector with SEQ_W/CNT_W matching SEQ_DET_SEQ_W/SEQ_DET_CNT_W.
package seq_det_pkg;

    localparam int unsigned SEQ_DET_SEQ_W = 5;
    localparam int unsigned SEQ_DET_CNT_W = 8;

    // Bits needed to hold a length value in 0..w
    function automatic int unsigned len_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned SEQ_DET_LEN_W = len_width(SEQ_DET_SEQ_W);

    typedef enum logic [1:0] {
        IDLE,
        LOADED,
        ARMED,
        DONE
    } seq_det_state_e;

    typedef struct packed {
        logic [SEQ_DET_SEQ_W-1:0] pattern;
        logic [SEQ_DET_LEN_W-1:0] len;
        logic [SEQ_DET_CNT_W-1:0] target;
        logic                     overlap;
    } seq_det_cfg_t;

endpackage

// File: rtl/seq_detect_ctrl_matcher.sv
// seq_matcher: shift register, fill counter and masked pattern compare.
// hit is combinational and describes the bit being shifted in this cycle.
module seq_matcher
    import seq_det_pkg::*;
#(
    parameter int unsigned SEQ_W = SEQ_DET_SEQ_W,
    parameter int unsigned LEN_W = len_width(SEQ_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             overlap,
    input  logic             din,
    input  logic [SEQ_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             hit
);

    logic [SEQ_W-1:0] sh;
    logic [SEQ_W-1:0] sh_n;
    logic [SEQ_W-1:0] mask;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] fill_n;

    // Next shift/fill values and the masked compare against the pattern
    always_comb begin
        sh_n   = {sh[SEQ_W-2:0], din};
        fill_n = (fill >= len) ? len : fill + LEN_W'(1);
        mask   = ~({SEQ_W{1'b1}} << len);
        hit    = shift_en && (fill_n == len) && (((sh_n ^ pattern) & mask) == '0);
    end

    // History register; a non-overlapping hit restarts the window from empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh   <= '0;
            fill <= '0;
        end else if (clear) begin
            sh   <= '0;
            fill <= '0;
        end else if (shift_en) begin
            if (hit && !overlap) begin
                sh   <= '0;
                fill <= '0;
            end else begin
                sh   <= sh_n;
                fill <= fill_n;
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run-time controller for the serial sequence detector.
// Optional idle timeout is built when SEQ_DET_TIMEOUT_EN is defined.
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned SEQ_W = SEQ_DET_SEQ_W,
    parameter int unsigned CNT_W = SEQ_DET_CNT_W,
    parameter int unsigned TO_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [SEQ_W-1:0]           cfg_pattern,
    input  logic [$clog2(SEQ_W+1)-1:0] cfg_len,
    input  logic [CNT_W-1:0]           cfg_target,
    input  logic                       cfg_overlap,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       din_valid,
    input  logic                       din,
    input  logic [TO_W-1:0]            to_limit,
    output logic                       match,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout
);

    localparam int unsigned LEN_W = len_width(SEQ_W);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(SEQ_W);

    seq_det_state_e   state;
    seq_det_cfg_t     cfg_q;
    seq_det_cfg_t     cfg_in;
    logic             match_q;
    logic [CNT_W-1:0] cnt;
    logic             done_q;
    logic             cfg_hs;
    logic             arm;
    logic             shift_en;
    logic             hit;
    logic             to_hit;

    // Handshake/arm decode and latch-time length clamp
    always_comb begin
        cfg_hs         = cfg_valid && (state != ARMED);
        arm            = start && ((state == LOADED) || (state == DONE));
        shift_en       = (state == ARMED) && din_valid && !abort;
        cfg_in.pattern = cfg_pattern;
        cfg_in.len     = ((cfg_len == '0) || (cfg_len > LEN_MAX)) ? LEN_MAX : cfg_len;
        cfg_in.target  = cfg_target;
        cfg_in.overlap = cfg_overlap;
    end

    seq_matcher #(
        .SEQ_W (SEQ_W),
        .LEN_W (LEN_W)
    ) u_matcher (
        .clk      (clk),
        .reset    (reset),
        .clear    (arm),
        .shift_en (shift_en),
        .overlap  (cfg_q.overlap),
        .din      (din),
        .pattern  (cfg_q.pattern),
        .len      (cfg_q.len),
        .hit      (hit)
    );

`ifdef SEQ_DET_TIMEOUT_EN
    logic [TO_W-1:0] idle_cnt;
    logic            timeout_q;

    // Idle-cycle limit reached this cycle (a match or abort takes precedence)
    always_comb begin
        to_hit = (state == ARMED) && !abort && !(shift_en && hit) &&
                 (to_limit != '0) && ((idle_cnt + TO_W'(1)) == to_limit);
    end

    // Idle counter: restarts on arming and on every match
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (arm || (shift_en && hit)) begin
            idle_cnt <= '0;
        end else if (state == ARMED) begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end

    // Sticky timeout flag, cleared by the next start or configuration load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (arm || cfg_hs) begin
            timeout_q <= 1'b0;
        end else if (to_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_to_limit;

    assign unused_to_limit = ^to_limit;
    assign to_hit          = 1'b0;
    assign timeout         = 1'b0;
`endif

    // Controller FSM with registered match pulse, counter and done level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cfg_q   <= '0;
            match_q <= 1'b0;
            cnt     <= '0;
            done_q  <= 1'b0;
        end else begin
            match_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_hs) begin
                        cfg_q <= cfg_in;
                        state <= LOADED;
                    end
                end
                LOADED, DONE: begin
                    if (start) begin
                        state  <= ARMED;
                        cnt    <= '0;
                        done_q <= 1'b0;
                    end else if (cfg_hs) begin
                        cfg_q  <= cfg_in;
                        state  <= LOADED;
                        done_q <= 1'b0;
                    end
                end
                ARMED: begin
                    if (abort) begin
                        state <= LOADED;
                    end else if (shift_en && hit) begin
                        match_q <= 1'b1;
                        cnt     <= (cnt == '1) ? cnt : cnt + CNT_W'(1);
                        if ((cfg_q.target != '0) && ((cnt + CNT_W'(1)) == cfg_q.target)) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end else if (to_hit) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cfg_ready = (state != ARMED);
    assign busy      = (state == ARMED);
    assign done      = done_q;
    assign match     = match_q;
    assign match_cnt = cnt;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl.
// Timeout checks follow SEQ_DET_TIMEOUT_EN.
module tb_seq_detect_ctrl;

    localparam int unsigned SEQ_W = 5;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned TO_W  = 16;
    localparam int unsigned LEN_W = $clog2(SEQ_W + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [SEQ_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_target;
    logic             cfg_overlap;
    logic             start;
    logic             abort;
    logic             din_valid;
    logic             din;
    logic [TO_W-1:0]  to_limit;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;
    logic             done;
    logic             timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(
        .SEQ_W (SEQ_W),
        .CNT_W (CNT_W),
        .TO_W  (TO_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_target  (cfg_target),
        .cfg_overlap (cfg_overlap),
        .start       (start),
        .abort       (abort),
        .din_valid   (din_valid),
        .din         (din),
        .to_limit    (to_limit),
        .match       (match),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [SEQ_W-1:0] p, input logic [LEN_W-1:0] l,
                            input logic [CNT_W-1:0] t, input logic ov);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_target  = t;
        cfg_overlap = ov;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic bit_in(input logic b, input logic exp_m, input string tag);
        din_valid = 1'b1;
        din       = b;
        tick();
        din_valid = 1'b0;
        chk1(tag, match, exp_m);
    endtask

    // bits/exp listed oldest-first in the MSBs: bit i of the stream is bits[n-1-i]
    task automatic stream(input logic [15:0] bits, input logic [15:0] exp_m,
                          input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bit_in(bits[n-1-i], exp_m[n-1-i], $sformatf("%s_b%0d", tag, i + 1));
        end
    endtask

    initial begin
        reset       = 1'b1;
        cfg_valid   = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_target  = '0;
        cfg_overlap = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        din_valid   = 1'b0;
        din         = 1'b0;
        to_limit    = '0;
        #2;
        chk1("rst_match", match, 1'b0);
        chk8("rst_cnt", match_cnt, 8'd0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);
        chk1("rst_ready", cfg_ready, 1'b1);
        tick();
        reset = 1'b0;
        tick();

        // 1: 10110 len 5, target 2, overlapping
        load_cfg(5'b10110, 3'd5, 8'd2, 1'b1);
        chk1("t1_ready_loaded", cfg_ready, 1'b1);
        chk1("t1_busy_loaded", busy, 1'b0);
        arm();
        chk1("t1_busy_armed", busy, 1'b1);
        chk1("t1_ready_armed", cfg_ready, 1'b0);
        stream(16'b10_1101_0110, 16'b00_0010_0001, 10, "t1");
        chk8("t1_cnt", match_cnt, 8'd2);
        chk1("t1_done", done, 1'b1);
        chk1("t1_busy_done", busy, 1'b0);
        chk1("t1_ready_done", cfg_ready, 1'b1);
        tick();
        chk1("t1_done_level", done, 1'b1);
        chk1("t1_match_gone", match, 1'b0);

        // 2: 101 len 3, unlimited, overlap then no overlap
        load_cfg(5'b00101, 3'd3, 8'd0, 1'b1);
        chk1("t2_done_cleared", done, 1'b0);
        arm();
        stream(16'b1_0101, 16'b0_0101, 5, "t2ov");
        chk8("t2ov_cnt", match_cnt, 8'd2);
        chk1("t2ov_busy", busy, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk1("t2_abort_busy", busy, 1'b0);
        chk8("t2_abort_cnt_kept", match_cnt, 8'd2);
        load_cfg(5'b00101, 3'd3, 8'd0, 1'b0);
        arm();
        chk8("t2_arm_clears_cnt", match_cnt, 8'd0);
        stream(16'b1_0101, 16'b0_0100, 5, "t2no");
        chk8("t2no_cnt", match_cnt, 8'd1);
        chk1("t2no_done", done, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // 3: 000 len 3 with valid gaps
        load_cfg(5'b00000, 3'd3, 8'd0, 1'b1);
        arm();
        bit_in(1'b0, 1'b0, "t3_b1");
        tick();
        chk1("t3_gap1", match, 1'b0);
        bit_in(1'b0, 1'b0, "t3_b2");
        tick();
        tick();
        chk1("t3_gap2", match, 1'b0);
        bit_in(1'b0, 1'b1, "t3_b3");
        tick();
        chk1("t3_pulse_one_cycle", match, 1'b0);
        bit_in(1'b0, 1'b1, "t3_b4");
        chk8("t3_cnt", match_cnt, 8'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // din ignored outside ARMED
        stream(16'b1_0110, 16'b0_0000, 5, "t3_loaded_din");
        chk8("t3_loaded_cnt", match_cnt, 8'd2);

        // 4: abort with the completing bit; len 0 clamps to 5
        load_cfg(5'b10110, 3'd0, 8'd0, 1'b1);
        arm();
        stream(16'b1011, 16'b0000, 4, "t4");
        abort     = 1'b1;
        din_valid = 1'b1;
        din       = 1'b0;
        tick();
        abort     = 1'b0;
        din_valid = 1'b0;
        chk1("t4_abort_match", match, 1'b0);
        chk8("t4_abort_cnt", match_cnt, 8'd0);
        chk1("t4_abort_busy", busy, 1'b0);
        chk1("t4_abort_ready", cfg_ready, 1'b1);

        // 5: three matches then reset mid-run
        arm();
        stream(16'b101_1010_1101_0110, 16'b000_0100_0010_0001, 15, "t5");
        chk8("t5_cnt3", match_cnt, 8'd3);
        reset = 1'b1;
        #1;
        chk8("t5_rst_cnt", match_cnt, 8'd0);
        chk1("t5_rst_busy", busy, 1'b0);
        chk1("t5_rst_done", done, 1'b0);
        chk1("t5_rst_ready", cfg_ready, 1'b1);
        tick();
        reset = 1'b0;
        arm();
        chk1("t5_start_ignored", busy, 1'b0);
        stream(16'b1_0110, 16'b0_0000, 5, "t5_idle_din");

        // 6: idle timeout
        to_limit = 16'd4;
        load_cfg(5'b10110, 3'd5, 8'd0, 1'b1);
        arm();
        tick();
        tick();
        tick();
        chk1("t6_busy_3", busy, 1'b1);
        chk1("t6_to_3", timeout, 1'b0);
        tick();
`ifdef SEQ_DET_TIMEOUT_EN
        chk1("t6_done_4", done, 1'b1);
        chk1("t6_to_4", timeout, 1'b1);
        chk1("t6_busy_4", busy, 1'b0);
        tick();
        chk1("t6_to_sticky", timeout, 1'b1);
        load_cfg(5'b10110, 3'd5, 8'd0, 1'b1);
        chk1("t6_to_cleared", timeout, 1'b0);
        chk1("t6_done_cleared", done, 1'b0);
`else
        for (int i = 0; i < 6; i++) tick();
        chk1("t6_busy_still", busy, 1'b1);
        chk1("t6_done_never", done, 1'b0);
        chk1("t6_to_tied", timeout, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Run-time controller for the programmable serial sequence detector path.
- Accepts a pattern configuration over a valid/ready handshake, with pattern, active length, target match count and overlap policy.
- Arms and disarms detection, and gates the serial input with a valid strobe.
- Matches variable-length patterns using an internal shift register and mask compare.
- Counts matches and reports completion to the system sequencer.

Parameters:
SEQ_W, 5, maximum pattern length in bits (>=2)
CNT_W, 8, width of the match target and match counter
TO_W, 16, width of the timeout limit (used only with SEQ_DET_TIMEOUT_EN)

Ports:
clk  input  1  clock; all logic on the rising edge
reset  input  1  asynchronous, active-high reset
cfg_valid  input  1  configuration offer
cfg_ready  output  1  configuration accepted when cfg_valid && cfg_ready
cfg_pattern  input  SEQ_W  pattern; bit 0 = most recent bit, bit len-1 = oldest bit
cfg_len  input  $clog2(SEQ_W+1)  active pattern length
cfg_target  input  CNT_W  matches required for done; 0 = unlimited
cfg_overlap  input  1  1 = overlapping matches allowed
start  input  1  arm the detector with the loaded configuration
abort  input  1  disarm the detector
din_valid  input  1  qualifies din
din  input  1  serial data bit
to_limit  input  TO_W  idle-cycle timeout; 0 = disabled
match  output  1  one-cycle pulse per detected match
match_cnt  output  CNT_W  matches in the current run, saturating
busy  output  1  high in ARMED
done  output  1  level, high in DONE
timeout  output  1  sticky flag: the run ended by timeout

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to IDLE; shift register, fill count, match, match_cnt, done and timeout all go to 0.
  - cfg_ready = 1.
- States and transitions:
  - IDLE: a cfg handshake latches pattern/len/target/overlap and moves to LOADED.
  - LOADED: start moves to ARMED, clearing the shift register, fill count, match_cnt and timeout. A cfg handshake reloads the configuration and stays in LOADED.
  - ARMED: abort moves to LOADED with match_cnt retained. Reaching the target moves to DONE.
  - DONE: start re-arms with the same configuration and the same clears. A cfg handshake moves to LOADED and clears done.
- cfg_ready = 1 in IDLE, LOADED and DONE; 0 in ARMED.
- Priority in LOADED and DONE: start beats cfg handshake.
- cfg_len of 0 or greater than SEQ_W is clamped to SEQ_W at latch time.
- Per din_valid in ARMED:
  - Shift: sh_n = {sh[SEQ_W-2:0], din}.
  - Fill count: fill_n = min(fill+1, len).
  - Hit condition: fill_n == len and (sh_n & mask) == (pattern & mask), where mask = low len bits.
- On a hit:
  - match pulses for one cycle, registered, one cycle after the accepted bit.
  - match_cnt increments, saturating at all-ones.
  - If overlap = 0, the shift register and fill count clear to 0 in the same update.
  - If target != 0 and match_cnt+1 == target, move to DONE on the same edge; done is high the next cycle.
- Bits with din_valid = 0 are ignored; the shift register holds.
- din_valid outside ARMED is ignored.
- abort in the same cycle as a completing bit: abort wins. No match, no count, state goes to LOADED.
- Reset mid-run: immediate return to IDLE and the configuration is lost; a new cfg handshake is required.

Optional Feature:
- Macro: SEQ_DET_TIMEOUT_EN
- Defined:
  - An idle counter clears on entering ARMED and on each match.
  - It increments on every ARMED cycle with no match.
  - When to_limit != 0 and the counter reaches to_limit: move to DONE and set timeout = 1.
  - timeout stays set until the next start or cfg handshake.
  - abort in that cycle still wins.
- Undefined: to_limit is ignored, timeout is tied to 0, and no counter logic exists.

Decomposition:
- Shared package seq_det_pkg holds:
  - State enum seq_det_state_e {IDLE, LOADED, ARMED, DONE}
  - Length-width localparam helper
  - Configuration struct seq_det_cfg_t {pattern, len, target, overlap}
- One natural sub-module, seq_matcher, containing:
  - Shift register
  - Fill counter
  - Mask generation and compare
  - Inputs: shift_en, clear; output: hit
- The controller FSM, match counter and timeout stay in seq_detect_ctrl.

Test Plan:
1. pattern=5'b10110, len=5, target=2, overlap=1; start; stream 1,0,1,1,0,1,0,1,1,0 -> match pulses after bits 5 and 10, match_cnt=2, done=1, busy=0, cfg_ready=1.
2. pattern=3'b101, len=3, target=0; stream 1,0,1,0,1 -> overlap=1 gives 2 matches; overlap=0 gives 1 match; never done.
3. pattern=3'b000, len=3; start then zeros with din_valid gaps between them -> no match on bits 1–2; match on the 3rd valid bit only; gaps hold state.
4. Set up a 5'b10110 run; abort asserted together with the 5th valid bit -> no match pulse, match_cnt=0, state LOADED, cfg_ready=1.
5. reset asserted mid-ARMED with match_cnt=3 -> immediately match_cnt=0, busy=0, done=0, cfg_ready=1; start before a new cfg is ignored.
6. With the macro: to_limit=4, start, no din -> done=1 and timeout=1 after 4 ARMED cycles. Without the macro: stays ARMED and timeout=0.
